// File: rtl/tdma_port_bridge.sv
// tdma_port_bridge: Nios send/receive queues in front of the TDMA port.
// The TX queue drains in this node's slot only; RX captures and counts drops.
module tdma_port_bridge #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_SLOTS  = 4,
    parameter int SLOT_LEN   = 4,
    parameter int MY_SLOT    = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         sync_i,
    input  logic [ADDR_W-1:0]            send_addr_i,
    input  logic [DATA_W-1:0]            send_data_i,
    input  logic                         send_valid_i,
    output logic                         send_ready_o,
    output logic [ADDR_W-1:0]            recv_addr_o,
    output logic [DATA_W-1:0]            recv_data_o,
    output logic                         recv_valid_o,
    input  logic                         recv_ready_i,
    output logic [ADDR_W-1:0]            tdma_send_addr_o,
    output logic [DATA_W-1:0]            tdma_send_data_o,
    output logic                         tdma_send_valid_o,
    input  logic [ADDR_W-1:0]            tdma_recv_addr_i,
    input  logic [DATA_W-1:0]            tdma_recv_data_i,
    input  logic                         tdma_recv_valid_i,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_o,
    output logic [7:0]                   rx_drop_o
);

    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int CYC_W     = $clog2(SLOT_LEN);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LOAD_SLOT = (MY_SLOT + NUM_SLOTS - 1) % NUM_SLOTS;

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SLOT_LEN - 1);
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(LOAD_SLOT);
    localparam logic [SLOT_W-1:0] SLOT_MINE = SLOT_W'(MY_SLOT);
    localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);

    logic [CYC_W-1:0]  r_cyc;
    logic [SLOT_W-1:0] r_slot;

    logic [ADDR_W-1:0] r_tx_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_tx_data [FIFO_DEPTH];
    logic [PTR_W:0]    r_tx_wr;
    logic [PTR_W:0]    r_tx_rd;

    logic [ADDR_W-1:0] r_rx_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_rx_data [FIFO_DEPTH];
    logic [PTR_W:0]    r_rx_wr;
    logic [PTR_W:0]    r_rx_rd;

    logic              r_rx_valid_q;
    logic              r_rx_cap;
    logic [ADDR_W-1:0] r_rx_cap_addr;
    logic [DATA_W-1:0] r_rx_cap_data;
    logic [7:0]        r_rx_drop;

    logic [ADDR_W-1:0] r_snd_addr;
    logic [DATA_W-1:0] r_snd_data;
    logic              r_snd_valid;

    logic w_last_cyc;
    logic w_load;
    logic w_end;
    logic w_tx_full;
    logic w_tx_empty;
    logic w_tx_push;
    logic w_tx_pop;
    logic w_rx_full;
    logic w_rx_empty;
    logic w_rx_pop;
    logic w_rx_push;
    logic w_rx_drop;

    // Slot edge decode and FIFO status/handshake terms
    always_comb begin
        w_last_cyc = (r_cyc == CYC_LAST);
        w_load     = w_last_cyc && (r_slot == SLOT_LOAD) && !sync_i;
        w_end      = w_last_cyc && (r_slot == SLOT_MINE) && !sync_i;
        w_tx_empty = (r_tx_wr == r_tx_rd);
        w_tx_full  = (r_tx_wr[PTR_W] != r_tx_rd[PTR_W])
                  && (r_tx_wr[PTR_W-1:0] == r_tx_rd[PTR_W-1:0]);
        w_rx_empty = (r_rx_wr == r_rx_rd);
        w_rx_full  = (r_rx_wr[PTR_W] != r_rx_rd[PTR_W])
                  && (r_rx_wr[PTR_W-1:0] == r_rx_rd[PTR_W-1:0]);
        w_tx_push  = send_valid_i && !w_tx_full;
        w_tx_pop   = w_load && !w_tx_empty;
        w_rx_pop   = recv_ready_i && !w_rx_empty;
        w_rx_push  = r_rx_cap && (!w_rx_full || w_rx_pop);
        w_rx_drop  = r_rx_cap && w_rx_full && !w_rx_pop;
    end

    // Cycle-within-slot and slot-within-frame counters, resync on sync_i
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_cyc  <= '0;
            r_slot <= '0;
        end else if (sync_i) begin
            r_cyc  <= '0;
            r_slot <= '0;
        end else if (w_last_cyc) begin
            r_cyc  <= '0;
            r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_ONE;
        end else begin
            r_cyc  <= r_cyc + CYC_ONE;
        end
    end

    // TX queue storage; occupancy lives in the pointers below
    always_ff @(posedge clk_clk) begin
        if (w_tx_push) begin
            r_tx_addr[r_tx_wr[PTR_W-1:0]] <= send_addr_i;
            r_tx_data[r_tx_wr[PTR_W-1:0]] <= send_data_i;
        end
    end

    // TX queue pointers
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
        end
    end

    // Network transmit register: load before our slot, clear at its end
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_snd_addr  <= '0;
            r_snd_data  <= '0;
            r_snd_valid <= 1'b0;
        end else if (sync_i) begin
            r_snd_valid <= 1'b0;
        end else if (w_tx_pop) begin
            r_snd_addr  <= r_tx_addr[r_tx_rd[PTR_W-1:0]];
            r_snd_data  <= r_tx_data[r_tx_rd[PTR_W-1:0]];
            r_snd_valid <= 1'b1;
        end else if (w_end) begin
            r_snd_valid <= 1'b0;
        end
    end

    // Receive edge detect; one capture per packet held for a whole slot
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_rx_valid_q  <= 1'b0;
            r_rx_cap      <= 1'b0;
            r_rx_cap_addr <= '0;
            r_rx_cap_data <= '0;
        end else begin
            r_rx_valid_q  <= tdma_recv_valid_i;
            r_rx_cap      <= tdma_recv_valid_i && !r_rx_valid_q;
            r_rx_cap_addr <= tdma_recv_addr_i;
            r_rx_cap_data <= tdma_recv_data_i;
        end
    end

    // RX queue storage; a full queue with a pop frees the head slot
    always_ff @(posedge clk_clk) begin
        if (w_rx_push) begin
            r_rx_addr[r_rx_wr[PTR_W-1:0]] <= r_rx_cap_addr;
            r_rx_data[r_rx_wr[PTR_W-1:0]] <= r_rx_cap_data;
        end
    end

    // RX queue pointers and saturating drop counter
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_rx_wr   <= '0;
            r_rx_rd   <= '0;
            r_rx_drop <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
            if (w_rx_drop && (r_rx_drop != 8'hFF))
                r_rx_drop <= r_rx_drop + 8'd1;
        end
    end

    // Outputs straight from flops
    always_comb begin
        send_ready_o      = !w_tx_full;
        recv_valid_o      = !w_rx_empty;
        recv_addr_o       = r_rx_addr[r_rx_rd[PTR_W-1:0]];
        recv_data_o       = r_rx_data[r_rx_rd[PTR_W-1:0]];
        tdma_send_addr_o  = r_snd_addr;
        tdma_send_data_o  = r_snd_data;
        tdma_send_valid_o = r_snd_valid;
        slot_o            = r_slot;
        rx_drop_o         = r_rx_drop;
    end

endmodule

// File: tb/tb_tdma_port_bridge.sv
// tb_tdma_port_bridge: directed tests for tdma_port_bridge.
// NUM_SLOTS=4, SLOT_LEN=4, MY_SLOT=2, FIFO_DEPTH=4.
module tb_tdma_port_bridge;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        sync_i = 1'b0;
    logic [7:0]  send_addr_i = '0;
    logic [31:0] send_data_i = '0;
    logic        send_valid_i = 1'b0;
    logic        send_ready_o;
    logic [7:0]  recv_addr_o;
    logic [31:0] recv_data_o;
    logic        recv_valid_o;
    logic        recv_ready_i = 1'b0;
    logic [7:0]  tdma_send_addr_o;
    logic [31:0] tdma_send_data_o;
    logic        tdma_send_valid_o;
    logic [7:0]  tdma_recv_addr_i = '0;
    logic [31:0] tdma_recv_data_i = '0;
    logic        tdma_recv_valid_i = 1'b0;
    logic [1:0]  slot_o;
    logic [7:0]  rx_drop_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    tdma_port_bridge #(
        .ADDR_W(8), .DATA_W(32), .NUM_SLOTS(4),
        .SLOT_LEN(4), .MY_SLOT(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .sync_i(sync_i),
        .send_addr_i(send_addr_i),
        .send_data_i(send_data_i),
        .send_valid_i(send_valid_i),
        .send_ready_o(send_ready_o),
        .recv_addr_o(recv_addr_o),
        .recv_data_o(recv_data_o),
        .recv_valid_o(recv_valid_o),
        .recv_ready_i(recv_ready_i),
        .tdma_send_addr_o(tdma_send_addr_o),
        .tdma_send_data_o(tdma_send_data_o),
        .tdma_send_valid_o(tdma_send_valid_o),
        .tdma_recv_addr_i(tdma_recv_addr_i),
        .tdma_recv_data_i(tdma_recv_data_i),
        .tdma_recv_valid_i(tdma_recv_valid_i),
        .slot_o(slot_o),
        .rx_drop_o(rx_drop_o)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk_clk);
        cyc++;
    endtask

    // Leaves the bench at the negedge inside cycle 0 (slot 0, cyc 0)
    task automatic do_reset();
        @(negedge clk_clk);
        reset_reset_n     = 1'b0;
        sync_i            = 1'b0;
        send_valid_i      = 1'b0;
        recv_ready_i      = 1'b0;
        tdma_recv_valid_i = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (slot_o !== 2'd0) begin
            n_err++; $display("FAIL rst_slot: got %0d required 0", slot_o);
        end
        n_vec++;
        if (send_ready_o !== 1'b1) begin
            n_err++; $display("FAIL rst_ready: got %b required 1", send_ready_o);
        end
        n_vec++;
        if (recv_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rst_rvalid: got %b required 0", recv_valid_o);
        end
        n_vec++;
        if (tdma_send_valid_o !== 1'b0 || tdma_send_addr_o !== 8'h00
            || tdma_send_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL rst_tx: got v=%b a=%h d=%h required 0/00/0",
                     tdma_send_valid_o, tdma_send_addr_o, tdma_send_data_o);
        end
        n_vec++;
        if (rx_drop_o !== 8'd0) begin
            n_err++; $display("FAIL rst_drop: got %0d required 0", rx_drop_o);
        end
    endtask

    task automatic test_idle();
        logic [1:0] exp_slot;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            exp_slot = 2'((c / 4) % 4);
            n_vec++;
            if (slot_o !== exp_slot || tdma_send_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL idle c%0d: got slot=%0d v=%b required slot=%0d v=0",
                         c, slot_o, tdma_send_valid_o, exp_slot);
            end
            step();
        end
    endtask

    task automatic test_single_send();
        logic exp_v;
        do_reset();
        step(); step();
        send_addr_i  = 8'h05;
        send_data_i  = 32'hDEADBEEF;
        send_valid_i = 1'b1;
        step();
        send_valid_i = 1'b0;
        while (cyc <= 13) begin
            exp_v = (cyc >= 8 && cyc <= 11);
            n_vec++;
            if (tdma_send_valid_o !== exp_v) begin
                n_err++;
                $display("FAIL send_valid c%0d: got %b required %b",
                         cyc, tdma_send_valid_o, exp_v);
            end
            if (exp_v) begin
                n_vec++;
                if (tdma_send_addr_o !== 8'h05
                    || tdma_send_data_o !== 32'hDEADBEEF) begin
                    n_err++;
                    $display("FAIL send_pkt c%0d: got %h/%h required 05/deadbeef",
                             cyc, tdma_send_addr_o, tdma_send_data_o);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic exp_rdy;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_rdy = (i < 4);
            n_vec++;
            if (send_ready_o !== exp_rdy) begin
                n_err++;
                $display("FAIL b2b_ready p%0d: got %b required %b",
                         i, send_ready_o, exp_rdy);
            end
            send_addr_i  = 8'(8'h20 + i);
            send_data_i  = 32'hA000_0000 + i;
            send_valid_i = 1'b1;
            step();
        end
        send_valid_i = 1'b0;
        while (cyc <= 72) begin
            if (cyc == 8 || cyc == 24 || cyc == 40 || cyc == 56) begin
                k = (cyc - 8) / 16;
                n_vec++;
                if (tdma_send_valid_o !== 1'b1
                    || tdma_send_addr_o !== 8'(8'h20 + k)
                    || tdma_send_data_o !== 32'hA000_0000 + k) begin
                    n_err++;
                    $display("FAIL b2b_pkt c%0d: got v=%b %h/%h required 1 %h/%h",
                             cyc, tdma_send_valid_o, tdma_send_addr_o,
                             tdma_send_data_o, 8'(8'h20 + k), 32'hA000_0000 + k);
                end
            end
            if (cyc == 7 || cyc == 23 || cyc == 72) begin
                n_vec++;
                if (tdma_send_valid_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_idle c%0d: got %b required 0",
                             cyc, tdma_send_valid_o);
                end
            end
            if (cyc == 8) begin
                n_vec++;
                if (send_ready_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready_after_pop: got %b required 1",
                             send_ready_o);
                end
            end
            step();
        end
    endtask

    task automatic test_recv_once();
        do_reset();
        step(); step();
        tdma_recv_addr_i  = 8'h11;
        tdma_recv_data_i  = 32'h12345678;
        tdma_recv_valid_i = 1'b1;
        n_vec++;
        if (recv_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rx_c2: got %b required 0", recv_valid_o);
        end
        step();
        n_vec++;
        if (recv_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rx_c3: got %b required 0", recv_valid_o);
        end
        step();
        n_vec++;
        if (recv_valid_o !== 1'b1 || recv_addr_o !== 8'h11
            || recv_data_o !== 32'h12345678) begin
            n_err++;
            $display("FAIL rx_c4: got v=%b %h/%h required 1 11/12345678",
                     recv_valid_o, recv_addr_o, recv_data_o);
        end
        step(); step();
        tdma_recv_valid_i = 1'b0;
        step();
        recv_ready_i = 1'b1;
        step();
        recv_ready_i = 1'b0;
        n_vec++;
        if (recv_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rx_once: got recv_valid=%b required 0", recv_valid_o);
        end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] exp_a [4];
        exp_a[0] = 8'h41; exp_a[1] = 8'h42;
        exp_a[2] = 8'h43; exp_a[3] = 8'h46;
        do_reset();
        step();
        for (int j = 0; j < 6; j++) begin
            tdma_recv_addr_i  = 8'(8'h40 + j);
            tdma_recv_data_i  = 32'hB000_0000 + j;
            tdma_recv_valid_i = 1'b1;
            step(); step();
            tdma_recv_valid_i = 1'b0;
            step(); step();
        end
        n_vec++;
        if (rx_drop_o !== 8'd2) begin
            n_err++; $display("FAIL ovf_drop: got %0d required 2", rx_drop_o);
        end
        n_vec++;
        if (recv_valid_o !== 1'b1 || recv_addr_o !== 8'h40
            || recv_data_o !== 32'hB000_0000) begin
            n_err++;
            $display("FAIL ovf_head: got v=%b %h/%h required 1 40/b0000000",
                     recv_valid_o, recv_addr_o, recv_data_o);
        end
        tdma_recv_addr_i  = 8'h46;
        tdma_recv_data_i  = 32'hB000_0006;
        tdma_recv_valid_i = 1'b1;
        step();
        recv_ready_i = 1'b1;
        step();
        recv_ready_i      = 1'b0;
        tdma_recv_valid_i = 1'b0;
        n_vec++;
        if (rx_drop_o !== 8'd2) begin
            n_err++; $display("FAIL ovf_pop_drop: got %0d required 2", rx_drop_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (recv_valid_o !== 1'b1 || recv_addr_o !== exp_a[i]) begin
                n_err++;
                $display("FAIL ovf_drain %0d: got v=%b a=%h required 1 %h",
                         i, recv_valid_o, recv_addr_o, exp_a[i]);
            end
            recv_ready_i = 1'b1;
            step();
        end
        recv_ready_i = 1'b0;
        n_vec++;
        if (recv_valid_o !== 1'b0) begin
            n_err++; $display("FAIL ovf_empty: got %b required 0", recv_valid_o);
        end
    endtask

    task automatic test_sync();
        do_reset();
        send_addr_i  = 8'h77;
        send_data_i  = 32'hCAFEF00D;
        send_valid_i = 1'b1;
        step();
        send_valid_i = 1'b0;
        while (cyc < 9) step();
        n_vec++;
        if (tdma_send_valid_o !== 1'b1 || slot_o !== 2'd2) begin
            n_err++;
            $display("FAIL sync_pre: got v=%b slot=%0d required 1 2",
                     tdma_send_valid_o, slot_o);
        end
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        n_vec++;
        if (slot_o !== 2'd0 || tdma_send_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL sync_post: got slot=%0d v=%b required 0 0",
                     slot_o, tdma_send_valid_o);
        end
        while (cyc < 18) step();
        n_vec++;
        if (slot_o !== 2'd2 || tdma_send_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL sync_noreq: got slot=%0d v=%b required 2 0",
                     slot_o, tdma_send_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_addr_i  = 8'h99;
        send_data_i  = 32'h0BADCAFE;
        send_valid_i = 1'b1;
        step();
        send_valid_i      = 1'b0;
        tdma_recv_addr_i  = 8'h33;
        tdma_recv_data_i  = 32'h33333333;
        tdma_recv_valid_i = 1'b1;
        step(); step();
        tdma_recv_valid_i = 1'b0;
        while (cyc < 9) step();
        n_vec++;
        if (tdma_send_valid_o !== 1'b1 || recv_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_pre: got tv=%b rv=%b required 1 1",
                     tdma_send_valid_o, recv_valid_o);
        end
        reset_reset_n = 1'b0;
        step();
        n_vec++;
        if (slot_o !== 2'd0 || tdma_send_valid_o !== 1'b0
            || tdma_send_addr_o !== 8'h00 || tdma_send_data_o !== 32'h0
            || send_ready_o !== 1'b1 || recv_valid_o !== 1'b0
            || rx_drop_o !== 8'd0) begin
            n_err++;
            $display("FAIL rmid_post: got slot=%0d tv=%b a=%h d=%h rdy=%b rv=%b drop=%0d required 0 0 00 0 1 0 0",
                     slot_o, tdma_send_valid_o, tdma_send_addr_o,
                     tdma_send_data_o, send_ready_o, recv_valid_o, rx_drop_o);
        end
        reset_reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_send();
        test_back_to_back();
        test_recv_once();
        test_rx_overflow();
        test_sync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdma_port_bridge.md
# tdma_port_bridge

Parametrised bridge between a Nios processor's send/receive ports and the TDMA network interface. It replaces the raw send/receive address and data PIOs with buffered, handshaked queues. The transmit FIFO is drained only during this node's own TDMA slot, timed by an internal slot counter. The receive FIFO captures each incoming packet exactly once, drops packets on overflow and counts the drops. It sits between the Nios system's PIO fabric and the TDMA network port.

## Interface
Parameters:
- ADDR_W, 8, packet destination/source address width
- DATA_W, 32, packet payload width
- NUM_SLOTS, 4, TDMA slots per frame; must be >= 2
- SLOT_LEN, 4, clock cycles per slot; must be >= 2
- MY_SLOT, 0, slot owned by this node, 0..NUM_SLOTS-1
- FIFO_DEPTH, 8, entries in each FIFO; power of two, >= 2

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset_n  in  1  synchronous, active-low reset
- sync_i  in  1  frame resync pulse
- send_addr_i  in  ADDR_W  CPU packet address
- send_data_i  in  DATA_W  CPU packet payload
- send_valid_i  in  1  CPU push request
- send_ready_o  out  1  transmit FIFO not full
- recv_addr_o  out  ADDR_W  head-of-queue address (first-word-fall-through)
- recv_data_o  out  DATA_W  head-of-queue payload
- recv_valid_o  out  1  receive FIFO not empty
- recv_ready_i  in  1  CPU pop
- tdma_send_addr_o  out  ADDR_W  network transmit address
- tdma_send_data_o  out  DATA_W  network transmit payload
- tdma_send_valid_o  out  1  transmit packet valid
- tdma_recv_addr_i  in  ADDR_W  network receive address
- tdma_recv_data_i  in  DATA_W  network receive payload
- tdma_recv_valid_i  in  1  receive packet valid; held by the network for the whole slot
- slot_o  out  clog2(NUM_SLOTS)  current slot number
- rx_drop_o  out  8  receive overflow count, saturating at 255

## Operation
- Slot timer: cyc_cnt counts 0..SLOT_LEN-1 and wraps. On wrap, slot_cnt increments and wraps from NUM_SLOTS-1 to 0. slot_o = slot_cnt.
- sync_i = 1: next cycle cyc_cnt = 0 and slot_cnt = 0. sync_i overrides the increment. A transmit packet in flight is cleared (tdma_send_valid_o = 0) but not re-queued.
- Load edge: cyc_cnt = SLOT_LEN-1 and slot_cnt = (MY_SLOT-1) mod NUM_SLOTS. If the transmit FIFO is non-empty, pop its head into the tdma_send_* registers and set valid to 1.
- End edge: cyc_cnt = SLOT_LEN-1 and slot_cnt = MY_SLOT. Clear valid; tdma_send_addr_o and tdma_send_data_o hold their last values.
- Transmit FIFO is empty at the load edge: valid stays 0 for that slot.
- Transmit push: send_valid_i & send_ready_o. send_ready_o = !tx_full.
  - When full, a push is refused even if a pop occurs on the same edge.
  - There is no bypass: a push on the load edge into an empty FIFO waits for the next frame.
- Receive capture: fires on the rising edge of tdma_recv_valid_i, i.e. valid & !valid_q. Captures {addr, data} once per packet.
- Receive push when full: the packet is dropped and rx_drop_o increments, saturating at 255.
  - Exception: if recv_ready_i pops the full FIFO on the same edge, the push is accepted and nothing is dropped.
- Receive pop: recv_valid_o & recv_ready_i. recv_valid_o = !rx_empty. recv_addr_o and recv_data_o always show the FIFO head.
- FIFOs use pointers one bit wider than log2(FIFO_DEPTH); pointer wrap-around is transparent. Simultaneous push and pop keeps the occupancy unchanged.

## Timing
- Reset values: all counters 0; both FIFOs empty; rx_drop_o = 0; slot_o = 0.
  - Outputs: send_ready_o = 1, recv_valid_o = 0, tdma_send_valid_o = 0, tdma_send_addr_o = 0, tdma_send_data_o = 0.
  - After reset release, cycle 0 is slot 0, cyc 0.
- Transmit: tdma_send_valid_o is high for exactly the SLOT_LEN cycles where slot_o = MY_SLOT (sync aside). At most one packet is sent per frame.
- Push-to-network latency ranges from 1 cycle (push immediately before the load edge) up to (FIFO position) × NUM_SLOTS × SLOT_LEN cycles.
- Receive: a packet is visible on recv_valid_o 2 cycles after tdma_recv_valid_i rises (1 cycle for the edge register, 1 cycle for the FIFO write).
- send_ready_o and recv_valid_o reflect the FIFO state registered at the previous edge. Both are combinational from flops only.
- Reset asserted mid-operation: on the next edge all state returns to reset values and FIFO contents are discarded.

## Test plan
Bench configuration: NUM_SLOTS=4, SLOT_LEN=4, MY_SLOT=2, FIFO_DEPTH=4.
- Reset, then idle for 32 cycles → slot_o cycles 0,0,0,0,1,… and tdma_send_valid_o stays 0.
- Push {0x05, 0xDEADBEEF} at cycle 2 → tdma_send_valid_o is high in cycles 8–11 with addr 0x05 and data 0xDEADBEEF; it is low at cycle 12.
- Push 5 packets back-to-back → the 5th is refused (send_ready_o = 0). The four accepted packets go out in cycles 8, 24, 40 and 56, in push order.
- Hold tdma_recv_valid_i high for 4 cycles with {0x11, 0x12345678} → exactly one entry, with recv_valid_o rising 2 cycles later. recv_ready_i pops it and recv_valid_o returns to 0.
- Send 6 receive packets with recv_ready_i = 0 → 4 are stored and rx_drop_o = 2. A packet arriving while full with a simultaneous pop is accepted and rx_drop_o stays at 2.
- Pulse sync_i during slot 2 with a packet in flight → slot_o = 0 the next cycle and tdma_send_valid_o drops. Pulse reset_reset_n low mid-frame → all outputs return to reset values on the next edge.
